pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_if.sv | 25 ++
 rtl/pulse_stretcher.sv | 93 +++++++++
 tb/tb_pulse_stretcher.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if -- request/status bundle for pulse_stretcher.
//   master : drives tick, duration, cancel; observes sig, busy, done, remaining
//   slave  : the stretcher itself
// WIDTH sets the duration / remaining width and must match the attached block.
interface pulse_stretcher_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic [WIDTH-1:0] duration;
  logic             cancel;
  logic             sig;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  modport master (
    output tick, duration, cancel,
    input  sig, busy, done, remaining
  );

  modport slave (
    input  tick, duration, cancel,
    output sig, busy, done, remaining
  );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher -- turns a single-cycle tick into a level pulse of
// 'duration' clock cycles, followed by a one-cycle done strobe.
//
// Ports:
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : pulse_stretcher_if.slave
//                tick/duration/cancel in, sig/busy/done/remaining out
//
// Build option:
//   PULSE_STRETCHER_RETRIGGER_EN -- when defined, a tick while the pulse is
//   running (no cancel, duration != 0) reloads the counter so the pulse runs
//   on for exactly 'duration' more cycles. When undefined, such ticks are
//   dropped.
//
// All outputs are decoded from registered state, so reset clears them
// immediately without waiting for a clock edge.
module pulse_stretcher #(
  parameter int WIDTH = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  pulse_stretcher_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic start_ok;
  assign start_ok = bus.tick && (bus.duration != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // cancel is meaningless outside a pulse; zero-length ticks fall to IDLE
        if (start_ok) begin
          state_d = ST_ACTIVE;
          cnt_d   = bus.duration;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (bus.cancel) begin
          // cancel beats any coincident tick; no done strobe on abort
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        else if (start_ok) begin
          cnt_d = bus.duration;
        end
`endif
        else if (cnt_q <= WIDTH'(1)) begin
          // last high cycle; counter never decrements past 1 here
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.sig       = (state_q == ST_ACTIVE);
  assign bus.busy      = (state_q == ST_ACTIVE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.remaining = (state_q == ST_ACTIVE) ? cnt_q : '0;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher -- scoreboard bench for pulse_stretcher.
// Each scenario lists tick/cancel cycles and the expected high segments and
// done cycles; per cycle the expected outputs are pushed when inputs are
// driven and popped/compared at the falling edge.
module tb_pulse_stretcher;

  localparam int W = 8;

  typedef struct packed {
    logic         sig;
    logic         done;
    logic [W-1:0] rem;
  } exp_t;

  logic clock;
  logic reset_n;

  pulse_stretcher_if #(.WIDTH(W)) bus ();

  pulse_stretcher #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t sb[$];

  // scenario description
  int tick_q[$];
  int tickd_q[$];
  int cancel_q[$];
  int seg_s[$];
  int seg_e[$];
  int seg_l[$];
  int done_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_scn();
    tick_q.delete();  tickd_q.delete(); cancel_q.delete();
    seg_s.delete();   seg_e.delete();   seg_l.delete();
    done_q.delete();
  endtask

  task automatic add_seg(input int s, input int e, input int l);
    seg_s.push_back(s); seg_e.push_back(e); seg_l.push_back(l);
  endtask

  task automatic add_tick(input int c, input int d);
    tick_q.push_back(c); tickd_q.push_back(d);
  endtask

  // segment (s,e,l): sig high from s to e, remaining counts down from l at s
  function automatic exp_t expect_at(input int c);
    exp_t x;
    x = '0;
    foreach (seg_s[i])
      if (c >= seg_s[i] && c <= seg_e[i]) begin
        x.sig = 1'b1;
        x.rem = W'(seg_l[i] - (c - seg_s[i]));
      end
    foreach (done_q[i])
      if (c == done_q[i]) x.done = 1'b1;
    return x;
  endfunction

  task automatic check_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_sig"},  bus.sig,       x.sig);
    chk({tag, "_busy"}, bus.busy,      x.sig);
    chk({tag, "_done"}, bus.done,      x.done);
    chk({tag, "_rem"},  bus.remaining, x.rem);
  endtask

  // Entered at posedge+1; leaves at posedge+1 after the last cycle.
  // Non-tick cycles carry random nonzero durations, which must not matter.
  task automatic run_scn(input string tag, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic         t, k;
      logic [W-1:0] d;
      t = 1'b0; k = 1'b0;
      d = W'($urandom_range(1, 255));
      foreach (tick_q[i])
        if (tick_q[i] == c) begin t = 1'b1; d = W'(tickd_q[i]); end
      foreach (cancel_q[i])
        if (cancel_q[i] == c) k = 1'b1;
      bus.tick     = t;
      bus.duration = d;
      bus.cancel   = k;
      sb.push_back(expect_at(c));
      @(negedge clock);
      check_out($sformatf("%s_c%0d", tag, c));
      @(posedge clock); #1;
    end
    bus.tick   = 1'b0;
    bus.cancel = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.tick     = 1'b0;
    bus.duration = '0;
    bus.cancel   = 1'b0;

    // reset state, with a tick pending to show reset dominates
    bus.tick = 1'b1; bus.duration = 8'd9;
    repeat (3) @(posedge clock);
    clear_scn();
    sb.push_back('0);
    @(negedge clock);
    check_out("reset");
    bus.tick = 1'b0;
    reset_n  = 1'b1;
    @(posedge clock); #1;

    // basic pulse: tick at 10, duration 5
    clear_scn();
    add_tick(10, 5); add_seg(11, 15, 5); done_q.push_back(16);
    run_scn("basic", 20);

    // zero duration is ignored
    clear_scn();
    add_tick(0, 0);
    run_scn("zero", 4);

    // cancel on the third high cycle: high 1..3, no done
    clear_scn();
    add_tick(0, 4); cancel_q.push_back(3); add_seg(1, 3, 4);
    run_scn("cancel", 8);

    // tick and cancel together while active: cancel wins
    clear_scn();
    add_tick(0, 4); add_tick(2, 7); cancel_q.push_back(2); add_seg(1, 2, 4);
    run_scn("cxt", 8);

    // second tick while active
    clear_scn();
    add_tick(0, 3); add_tick(2, 3);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    add_seg(1, 2, 3); add_seg(3, 5, 3); done_q.push_back(6);
`else
    add_seg(1, 3, 3); done_q.push_back(4);
`endif
    run_scn("retrig", 9);

    // retrigger tick with duration 0 is ignored in either build
    clear_scn();
    add_tick(0, 3); add_tick(2, 0); add_seg(1, 3, 3); done_q.push_back(4);
    run_scn("retrig0", 7);

    // tick in the done cycle starts a back-to-back pulse
    clear_scn();
    add_tick(0, 3); add_tick(4, 3);
    add_seg(1, 3, 3); add_seg(5, 7, 3);
    done_q.push_back(4); done_q.push_back(8);
    run_scn("b2b", 10);

    // max duration, interrupted by reset at pulse cycle 100
    clear_scn();
    add_tick(0, 255); add_seg(1, 255, 255);
    run_scn("max_pre", 100);
    #2 reset_n = 1'b0;
    #1;
    sb.push_back('0);
    check_out("async_rst");
    @(posedge clock);
    sb.push_back('0);
    @(negedge clock);
    check_out("rst_hold");
    // tick presented for the first edge after release
    reset_n      = 1'b1;
    bus.tick     = 1'b1;
    bus.duration = 8'd255;
    @(posedge clock); #1;
    bus.tick = 1'b0;
    clear_scn();
    add_seg(0, 254, 255); done_q.push_back(255);
    run_scn("max_full", 258);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case the flow above ever stalls
  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: got no finish, expected finish before %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
